// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control units: opcodes, multicycle state
// encodings, ALU/PC select encodings and the decoded opcode class.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RCOMP  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IDLE   = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One-hot class of the current opcode
  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_j;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/mips_op_decode.sv
// Combinational opcode classifier shared by the single- and multicycle control.
// Ports: op (IR[31:26]) -> op_class_c (one-hot opcode class).
module mips_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       op_class_c
);

  always_comb begin
    op_class_c = '0;
    case (op)
      OP_RTYPE: op_class_c.is_r       = 1'b1;
      OP_LW:    op_class_c.is_lw      = 1'b1;
      OP_SW:    op_class_c.is_sw      = 1'b1;
      OP_BEQ:   op_class_c.is_beq     = 1'b1;
      OP_J:     op_class_c.is_j       = 1'b1;
      default:  op_class_c.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// for R-type, lw, sw, beq and j, with a memory-ready handshake and a
// retired-instruction counter.
// Ports: clk, reset (async, active-high); op, mem_ready in; datapath control
// strobes/selects, instr_done, illegal_op, instr_count, state (debug) out.
// Control outputs are decoded from the state register (and mem_ready/op where
// the handshake needs same-cycle response), so they change with the state.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                IRWrite,
  output logic [1:0]          PCSource,
  output logic [1:0]          ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count,
  output logic [STATE_W-1:0]  state
);

  state_t    state_q;
  state_t    state_d;
  op_class_t op_class;

  mips_op_decode u_op_decode (
    .op         (op),
    .op_class_c (op_class)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and control decode
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      // PC+4 is written only on the cycle memory returns the instruction
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      // Branch target computed speculatively into ALUOut
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SL2;
        if (op_class.is_lw || op_class.is_sw) state_d = S_MEMADR;
        else if (op_class.is_r)                state_d = S_EXEC;
        else if (op_class.is_beq)              state_d = S_BRANCH;
        else if (op_class.is_j)                state_d = S_JUMP;
        else begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (op_class.is_lw)      state_d = S_MEMRD;
        else if (op_class.is_sw) state_d = S_MEMWR;
        else                     state_d = S_FETCH;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // Store retires on the cycle memory accepts the write
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_RCOMP;
      end

      S_RCOMP: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           instr_count <= '0;
    else if (instr_done) instr_count <= instr_count + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: the stimulus walks directed
// instruction sequences and queues the hand-computed per-cycle response; a
// monitor pops and compares on every falling edge.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  // Narrow counter keeps the wrap test short
  localparam int unsigned CNT_W = 10;

  // Expected control words, packed as
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //  PCSource[1:0],ALUOp[1:0],ALUSrcA,ALUSrcB[1:0],RegWrite,RegDst}
  localparam logic [15:0] W_IDLE   = 16'h0000;
  localparam logic [15:0] W_FWAIT  = 16'h1004; // MemRead, SrcB=4
  localparam logic [15:0] W_FGO    = 16'h9204; // + PCWrite, IRWrite
  localparam logic [15:0] W_DECODE = 16'h000C; // SrcB=imm<<2
  localparam logic [15:0] W_MEMADR = 16'h0018; // SrcA=A, SrcB=imm
  localparam logic [15:0] W_MEMRD  = 16'h3000; // IorD, MemRead
  localparam logic [15:0] W_MEMWB  = 16'h0402; // MemtoReg, RegWrite
  localparam logic [15:0] W_MEMWR  = 16'h2800; // IorD, MemWrite
  localparam logic [15:0] W_EXEC   = 16'h0050; // ALUOp=funct, SrcA=A
  localparam logic [15:0] W_RCOMP  = 16'h0003; // RegWrite, RegDst
  localparam logic [15:0] W_BRANCH = 16'h40B0; // PCWriteCond, PCSrc=01, ALUOp=sub, SrcA=A
  localparam logic [15:0] W_JUMP   = 16'h8100; // PCWrite, PCSrc=10

  typedef struct packed {
    logic [STATE_W-1:0] st;
    logic [15:0]        w;
    logic               done;
    logic               ill;
    logic [CNT_W-1:0]   cnt;
  } resp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [OP_W-1:0]  op;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic             ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [STATE_W-1:0] state;

  resp_t            exp_q[$];
  int               step_ids[$];
  int               checks   = 0;
  int               failures = 0;
  int               step_no  = 0;
  logic [CNT_W-1:0] exp_cnt;
  event             sample_ev;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  // Monitor: compare the live outputs against the oldest queued expectation
  always begin : monitor
    resp_t act;
    resp_t e;
    int    id;
    @(negedge clk or sample_ev);
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      id  = step_ids.pop_front();
      act = '{state,
              {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst},
              instr_done, illegal_op, instr_count};
      checks++;
      if (act != e) begin
        failures++;
        $display("FAIL step%0d: got state=%0d ctrl=%h done=%b ill=%b cnt=%0d, want state=%0d ctrl=%h done=%b ill=%b cnt=%0d",
                 id, act.st, act.w, act.done, act.ill, act.cnt,
                 e.st, e.w, e.done, e.ill, e.cnt);
      end
    end
  end

  // Queue one cycle's expectation (called at posedge+1), then advance a cycle
  task automatic push_exp(input logic [STATE_W-1:0] st, input logic [15:0] w,
                          input logic done, input logic ill);
    exp_q.push_back('{st, w, done, ill, exp_cnt});
    step_ids.push_back(step_no);
    step_no++;
    if (done) exp_cnt = exp_cnt + CNT_W'(1);
  endtask

  task automatic step(input logic mr, input logic [STATE_W-1:0] st,
                      input logic [15:0] w, input logic done, input logic ill);
    mem_ready = mr;
    push_exp(st, w, done, ill);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) step(1'b0, S_FETCH, W_FWAIT, 1'b0, 1'b0);
    step(1'b1, S_FETCH, W_FGO, 1'b0, 1'b0);
  endtask

  task automatic do_r(input int fwaits);
    op = OP_RTYPE;
    fetch(fwaits);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b0, S_EXEC,   W_EXEC,   1'b0, 1'b0);
    step(1'b1, S_RCOMP,  W_RCOMP,  1'b1, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset     = 1'b1;
    op        = OP_LW;
    mem_ready = 1'b1;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);

    // lw, memory always ready: 5 cycles
    op = OP_LW;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b1, S_MEMADR, W_MEMADR, 1'b0, 1'b0);
    step(1'b1, S_MEMRD,  W_MEMRD,  1'b0, 1'b0);
    step(1'b1, S_MEMWB,  W_MEMWB,  1'b1, 1'b0);
    checks++;
    if (instr_count != exp_cnt) begin
      failures++;
      $display("FAIL lw_count: got instr_count=%0d, want %0d", instr_count, exp_cnt);
    end

    // R-type
    do_r(0);

    // sw with three stalled cycles in MEMWR; mem_ready low elsewhere is ignored
    op = OP_SW;
    fetch(0);
    step(1'b0, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b0, S_MEMADR, W_MEMADR, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, S_MEMWR, W_MEMWR, 1'b0, 1'b0);
    step(1'b1, S_MEMWR, W_MEMWR, 1'b1, 1'b0);

    // Two-cycle fetch stall
    do_r(2);

    // beq then j
    op = OP_BEQ;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b1, S_BRANCH, W_BRANCH, 1'b1, 1'b0);
    op = OP_J;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b1, S_JUMP,   W_JUMP,   1'b1, 1'b0);

    // Illegal opcode: pulse in DECODE, straight back to FETCH, no retire
    op = 6'b111111;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b1);
    op = 6'b010101;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b1);

    // Counter wrap: clear, then 2^CNT_W + 1 R-type instructions
    reset = 1'b1;
    exp_cnt = '0;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);
    for (int n = 0; n < (1 << CNT_W) + 1; n++) do_r(0);
    checks++;
    if (instr_count != exp_cnt) begin
      failures++;
      $display("FAIL wrap_count: got instr_count=%0d, want %0d", instr_count, exp_cnt);
    end

    // lw interrupted by reset in the middle of a stalled MEMRD
    op = OP_LW;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);
    step(1'b1, S_MEMADR, W_MEMADR, 1'b0, 1'b0);
    mem_ready = 1'b0;
    push_exp(S_MEMRD, W_MEMRD, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset   = 1'b1;
    exp_cnt = '0;
    #1;
    checks++;
    if (state != S_IDLE) begin
      failures++;
      $display("FAIL async_reset_state: got state=%0d, want %0d", state, S_IDLE);
    end
    checks++;
    if (MemRead || MemWrite) begin
      failures++;
      $display("FAIL async_reset_mem: got MemRead=%b MemWrite=%b, want 0 0", MemRead, MemWrite);
    end
    checks++;
    if (instr_count != exp_cnt) begin
      failures++;
      $display("FAIL async_reset_count: got instr_count=%0d, want %0d", instr_count, exp_cnt);
    end
    push_exp(S_IDLE, W_IDLE, 1'b0, 1'b0);
    ->sample_ev;
    @(posedge clk);
    #1;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, S_IDLE, W_IDLE, 1'b0, 1'b0);
    op = OP_RTYPE;
    fetch(0);
    step(1'b1, S_DECODE, W_DECODE, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
